ahb_master_port: RTL

- Master-side AHB bus interface. It is the requesting end of the hbusreq/hgrant arbitration handshake.
- Accepts single read/write commands from a core-side valid/ready port. Raises hbusreq, waits for hgrant, issues one NONSEQ SINGLE transfer, and returns read data and error status on a one-cycle response strobe.
- One instance per bus master (e.g. instruction fetch, load/store), each connected to one hbusreq_N/hgrant_N pair of the bus arbiter.

---
 rtl/ahb_master_port.sv | 106 ++++++++++
 1 files changed

// File: rtl/ahb_master_port.sv
// ahb_master_port: single-transfer AHB master with hbusreq/hgrant arbitration and core valid/ready front end
module ahb_master_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_size,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              hbusreq,
    input  logic              hgrant,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic [1:0]        hresp
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ADDR, ST_DATA} state_t;
    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    state_t            state;
    logic [ADDR_W-1:0] a_addr;
    logic              a_write;
    logic [DATA_W-1:0] a_wdata;
    logic [2:0]        a_size;
    logic              accept;
    logic              misaligned;
    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept = req_valid && req_ready;
    assign misaligned = (req_size > 3'b010) ||
                        (req_size == 3'b001 && req_addr[0]) ||
                        (req_size == 3'b010 && req_addr[1:0] != 2'b00);
    assign hburst = 3'b000;
    // command latch, arbitration handshake, single NONSEQ transfer and response strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hbusreq   <= 1'b0;
            htrans    <= HT_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize     <= '0;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            a_addr    <= '0;
            a_write   <= 1'b0;
            a_wdata   <= '0;
            a_size    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    a_addr  <= req_addr;
                    a_write <= req_write;
                    a_wdata <= req_wdata;
                    a_size  <= req_size;
                    if (misaligned) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        hbusreq <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: if (hgrant && hready) begin
                    state  <= ST_ADDR;
                    htrans <= HT_NONSEQ;
                    haddr  <= a_addr;
                    hwrite <= a_write;
                    hsize  <= a_size;
                end
                ST_ADDR: if (hready) begin
                    htrans <= HT_IDLE;
                    if (hgrant) begin
                        state   <= ST_DATA;
                        hbusreq <= 1'b0;
                        hwdata  <= a_write ? a_wdata : '0;
                    end else begin
                        state <= ST_REQ;
                    end
                end
                ST_DATA: if (hready) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= a_write ? '0 : hrdata;
                    rsp_err   <= (hresp == 2'b01);
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
